mmu_data_port: RTL and testbench

- Memory-side responder for the decoder's load/store control signals (read_mmu, write_mmu, byte_select_mmu).
- Sits between the pipeline memory stage and the word-wide data memory bus.
- Stalls the pipeline while an access is in flight, sign-extends byte loads and builds byte-enable masks for stores.
- Flags misaligned word accesses and bus timeouts.

---
 rtl/mmu_data_port_pkg.sv | 16 +
 rtl/mmu_byte_lane.sv | 24 ++
 rtl/mmu_data_port.sv | 121 ++++++++++++
 tb/tb_mmu_data_port.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_data_port_pkg.sv
// mmu_data_port_pkg: shared state encodings and byte-enable constants for the memory ports
package mmu_data_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mmu_byte_lane.sv
// mmu_byte_lane: byte-enable generation, store-data replication and load-data extraction
module mmu_byte_lane
    import mmu_data_port_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic        byte_select,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data
);

    logic [7:0] lane_byte;

    // byte accesses touch one lane and sign-extend it; word accesses pass straight through
    always_comb begin
        lane_byte = 8'(mem_rdata >> {lane, 3'b000});
        be        = byte_select ? 4'b0001 << lane : BE_WORD;
        wdata_rep = byte_select ? {4{wdata[7:0]}} : wdata;
        load_data = byte_select ? sext8(lane_byte) : mem_rdata;
    end

endmodule

// File: rtl/mmu_data_port.sv
// mmu_data_port: load/store responder between the memory stage and the word-wide data bus
module mmu_data_port
    import mmu_data_port_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_mmu,
    input  logic        write_mmu,
    input  logic        byte_select_mmu,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    state_t             state, next_state;
    logic [31:0]        lat_addr, lat_wdata;
    logic               lat_byte, lat_we;
    logic [CNT_W-1:0]   cnt;
    logic               req, conflict, unaligned, timeout;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata, lane_load;
    logic [31:0]        rdata_d;
    logic               mis_d, err_d;

    mmu_byte_lane u_lane (
        .lane        (lat_addr[1:0]),
        .byte_select (lat_byte),
        .wdata       (lat_wdata),
        .mem_rdata   (mem_rdata),
        .be          (lane_be),
        .wdata_rep   (lane_wdata),
        .load_data   (lane_load)
    );

    // bus outputs come from the latched request and are forced low whenever no access is in flight
    assign mem_we    = mem_req & lat_we;
    assign mem_addr  = mem_req ? {lat_addr[31:2], 2'b00} : '0;
    assign mem_wdata = mem_req ? lane_wdata : '0;
    assign mem_be    = mem_req ? lane_be : '0;

    // next-state decode plus the result and flags to present during the DONE cycle
    always_comb begin
        req        = read_mmu | write_mmu;
        conflict   = read_mmu & write_mmu;
        unaligned  = ~byte_select_mmu & (addr[1:0] != 2'b00);
        timeout    = cnt == CNT_W'(MEM_TIMEOUT - 1);
        next_state = state;
        rdata_d    = '0;
        mis_d      = 1'b0;
        err_d      = 1'b0;
        stall      = 1'b0;
        unique case (state)
            IDLE: begin
                stall = req & rst_n;
                if (req) begin
                    next_state = (conflict | unaligned) ? DONE : BUSY;
                    err_d      = conflict;
                    mis_d      = ~conflict & unaligned;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ready) begin
                    next_state = DONE;
                    rdata_d    = lat_we ? '0 : lane_load;
                end else if (timeout) begin
                    next_state = DONE;
                    err_d      = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // request latch, timeout counter, registered bus request and one-cycle DONE results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_byte   <= 1'b0;
            lat_we     <= 1'b0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            rdata      <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                lat_addr  <= addr;
                lat_wdata <= wdata;
                lat_byte  <= byte_select_mmu;
                lat_we    <= write_mmu;
            end
            cnt        <= (state == BUSY) ? cnt + CNT_W'(1) : '0;
            mem_req    <= next_state == BUSY;
            rdata      <= rdata_d;
            misaligned <= mis_d;
            bus_err    <= err_d;
        end
    end

endmodule

// File: tb/tb_mmu_data_port.sv
// tb_mmu_data_port: randomized scoreboard bench with a byte-level memory reference model
module tb_mmu_data_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        read_mmu = 1'b0, write_mmu = 1'b0, byte_select_mmu = 1'b0;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic        mem_ready_m = 1'b0, stray = 1'b0;
    logic        mem_ready;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        stall, misaligned, bus_err, mem_req, mem_we;
    logic [3:0]  mem_be;

    assign mem_ready = mem_ready_m | stray;

    mmu_data_port dut (
        .clk(clk), .rst_n(rst_n), .read_mmu(read_mmu), .write_mmu(write_mmu),
        .byte_select_mmu(byte_select_mmu), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .misaligned(misaligned), .bus_err(bus_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          len;
    } bus_t;

    int          total = 0, bad = 0;
    resp_t       sb_q[$];
    bus_t        bus_q[$];
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] bus_mem [0:255];
    int          mem_delay = 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic set_word(input int a, input logic [31:0] w);
        bus_mem[a / 4] = w;
        for (int k = 0; k < 4; k++) ref_mem[a - a % 4 + k] = w[8*k +: 8];
    endtask

    // dly = cycles of mem_req before mem_ready (1..16); 0 = memory never answers
    task automatic access(input logic rd, input logic wr, input logic bs,
                          input int a, input logic [31:0] wd, input int dly);
        resp_t r;
        bus_t  b;
        int    n, v;
        logic  on_bus;
        r = '{rdata: 32'h0, mis: 1'b0, err: 1'b0};
        b = '{addr: 32'h0, be: 4'h0, we: 1'b0, wdata: 32'h0, len: 0};
        on_bus = 1'b0;
        if (rd && wr) r.err = 1'b1;
        else if (!bs && a % 4 != 0) r.mis = 1'b1;
        else begin
            on_bus  = 1'b1;
            b.addr  = 32'(a - a % 4);
            b.we    = wr;
            b.be    = bs ? 4'(1 << (a % 4)) : 4'hF;
            b.wdata = bs ? wd[7:0] * 32'h01010101 : wd;
            b.len   = (dly == 0) ? 16 : dly;
            if (dly == 0) r.err = 1'b1;
            else if (wr) begin
                if (bs) ref_mem[a] = wd[7:0];
                else for (int k = 0; k < 4; k++) ref_mem[a + k] = wd[8*k +: 8];
            end else if (bs) begin
                v = ref_mem[a];
                if (v >= 128) v -= 256;
                r.rdata = 32'(v);
            end else for (int k = 0; k < 4; k++) r.rdata[8*k +: 8] = ref_mem[a + k];
        end
        sb_q.push_back(r);
        if (on_bus) bus_q.push_back(b);
        mem_delay = dly;
        @(posedge clk);
        #1;
        read_mmu = rd; write_mmu = wr; byte_select_mmu = bs; addr = 32'(a); wdata = wd;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
        check("stall_len", 32'(n), on_bus ? 32'(1 + b.len) : 32'd1);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        read_mmu = 1'b0; write_mmu = 1'b0;
    endtask

    // monitor: the cycle where stall falls is DONE; compare it against the oldest expectation
    initial begin
        logic  prev;
        resp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) prev = 1'b0;
            else begin
                if (prev && !stall) begin
                    if (sb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL done_unexpected: got rdata %h with empty scoreboard", rdata);
                    end else begin
                        e = sb_q.pop_front();
                        check("rdata", rdata, e.rdata);
                        check("misaligned", 32'(misaligned), 32'(e.mis));
                        check("bus_err", 32'(bus_err), 32'(e.err));
                    end
                end else check("flags_outside_done", {30'd0, misaligned, bus_err}, 32'd0);
                prev = stall;
            end
        end
    end

    // bus-side memory: answers after mem_delay request cycles and checks the request it sees
    initial begin
        int   k;
        bus_t cur;
        k = 0;
        cur = '{addr: 32'h0, be: 4'h0, we: 1'b0, wdata: 32'h0, len: 0};
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                k = 0;
                mem_ready_m = 1'b0;
            end else if (mem_req) begin
                k++;
                if (k == 1) begin
                    if (bus_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL mem_req_unexpected: got mem_addr %h with no bus access expected", mem_addr);
                    end else cur = bus_q.pop_front();
                end
                check("mem_addr", mem_addr, cur.addr);
                check("mem_be", 32'(mem_be), 32'(cur.be));
                check("mem_we", 32'(mem_we), 32'(cur.we));
                if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                mem_ready_m = (k == mem_delay);
                if (mem_ready_m && mem_we) begin
                    for (int j = 0; j < 4; j++)
                        if (mem_be[j]) bus_mem[mem_addr[9:2]][8*j +: 8] = mem_wdata[8*j +: 8];
                    mem_rdata = $urandom;
                end else if (mem_ready_m) mem_rdata = bus_mem[mem_addr[9:2]];
                else mem_rdata = $urandom;
            end else begin
                if (k > 0) check("mem_req_len", 32'(k), 32'(cur.len));
                k = 0;
                mem_ready_m = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion within 1 ms");
        $fatal(1);
    end

    initial begin
        logic        rd, wr, bs;
        int          a, dly, kind, sel;
        logic [31:0] w;
        for (int i = 0; i < 256; i++) set_word(i * 4, $urandom);
        set_word(32'h100, 32'hDEADBEEF);
        set_word(32'h200, 32'h80FF1234);
        #1 rst_n = 1'b0;
        #20;
        check("rst_rdata", rdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_flags", {30'd0, misaligned, bus_err}, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1, 0, 0, 32'h100, 32'h0, 3);
        access(1, 0, 1, 32'h203, 32'h0, 2);
        access(1, 0, 1, 32'h202, 32'h0, 1);
        idle();
        access(0, 1, 1, 32'h301, 32'h000000A5, 2);
        access(1, 0, 0, 32'h300, 32'h0, 1);
        access(1, 0, 0, 32'h102, 32'h0, 1);
        access(1, 1, 0, 32'h104, 32'h0, 1);
        access(1, 0, 0, 32'h108, 32'h0, 0);
        access(1, 0, 0, 32'h10C, 32'h0, 16);
        idle();
        mem_delay = 0;
        bus_q.push_back('{addr: 32'h100, be: 4'hF, we: 1'b0, wdata: 32'h0, len: 0});
        @(posedge clk);
        #1;
        read_mmu = 1'b1; byte_select_mmu = 1'b0; addr = 32'h100;
        repeat (4) @(negedge clk);
        check("busy_stall", 32'(stall), 32'd1);
        check("busy_mem_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        read_mmu = 1'b0;
        #1;
        check("async_rst_stall", 32'(stall), 32'd0);
        check("async_rst_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        check("stray_ready_stall", 32'(stall), 32'd0);
        check("stray_ready_mem_req", 32'(mem_req), 32'd0);
        access(1, 0, 0, 32'h100, 32'h0, 2);
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 19);
            rd = (kind < 10) || (kind == 19);
            wr = kind >= 10;
            bs = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 1023);
            if (!bs && $urandom_range(0, 7) != 0) a = a - a % 4;
            sel = $urandom_range(0, 29);
            dly = (sel == 0) ? 0 : (sel == 1) ? 16 : $urandom_range(1, 5);
            w = $urandom;
            access(rd, wr, bs, a, w, dly);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        repeat (3) @(posedge clk);
        check("sb_q_drained", 32'(sb_q.size()), 32'd0);
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
